// File: rtl/conv1d_pkg.sv
// Shared definitions for the conv1d output packer: command opcodes,
// lane geometry, STATUS word layout and the packed word type.
package conv1d_pkg;

  localparam logic [6:0] OP_POP     = 7'd20;
  localparam logic [6:0] OP_STATUS  = 7'd21;
  localparam logic [6:0] OP_CLEAR   = 7'd22;
  localparam logic [6:0] OP_SET_PAD = 7'd23;
  localparam logic [6:0] OP_FLUSH   = 7'd24;
  localparam logic [6:0] OP_WORDS   = 7'd25;
  localparam logic [6:0] OP_STALLS  = 7'd26;

  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  // STATUS = {underflow, 21'b0, lane[1:0], fifo_count[7:0]}
  localparam int STAT_UNDERFLOW_BIT = 31;
  localparam int STAT_LANE_LSB      = 8;
  localparam int STAT_COUNT_LSB     = 0;

  typedef logic [31:0] packed_word_t;

  function automatic packed_word_t make_status(input logic underflow,
                                               input logic [LANE_W-1:0] lane,
                                               input logic [7:0] count_sat);
    packed_word_t s;
    s = '0;
    s[STAT_UNDERFLOW_BIT]          = underflow;
    s[STAT_LANE_LSB +: LANE_W]     = lane;
    s[STAT_COUNT_LSB +: 8]         = count_sat;
    return s;
  endfunction

endpackage

// File: rtl/packer_word_fifo.sv
// Single-clock word FIFO for the output packer. Pointers carry one extra
// wrap bit so full and empty are distinguishable; head data is read
// combinationally. Push on full and pop on empty are ignored.
module packer_word_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wptr == rptr);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; clear drops all stored words at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/conv1d_output_packer.sv
// conv1d output packer: gathers int8 results four at a time into
// little-endian 32-bit words, queues them in a word FIFO and serves
// them to the CPU through the CFU command port.
// Optional feature macro: CONV1D_PACKER_STATS_EN (push/stall counters,
// read via opcodes 25 and 26).
module conv1d_output_packer
  import conv1d_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int WORD_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  input  logic              cmd_valid,
  input  logic [6:0]        cmd,
  input  logic [WORD_W-1:0] cmd_arg,
  output logic [WORD_W-1:0] ret,
  output logic              ret_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [LANE_W-1:0] lane;
  packed_word_t      asm_word;
  packed_word_t      push_word;
  logic [7:0]        pad;
  logic              underflow;

  logic              pop_cmd;
  logic              clear_cmd;
  logic              pad_cmd;
  logic              flush_cmd;
  logic              accept;
  logic              byte_push;
  logic              flush_push;
  logic              fifo_push;
  logic              fifo_pop;
  packed_word_t      fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        count_sat;
  packed_word_t      result;
  packed_word_t      words_val;
  packed_word_t      stalls_val;
  logic              unused_arg_bits;

  assign unused_arg_bits = ^cmd_arg[WORD_W-1:8];

  assign pop_cmd   = cmd_valid && (cmd == OP_POP);
  assign clear_cmd = cmd_valid && (cmd == OP_CLEAR);
  assign pad_cmd   = cmd_valid && (cmd == OP_SET_PAD);
  assign flush_cmd = cmd_valid && (cmd == OP_FLUSH);

  assign in_ready   = rst_n && !fifo_full && !clear_cmd;
  assign accept     = in_valid && in_ready;
  assign byte_push  = accept && ((lane == LANE_W'(LANES-1)) || in_last || flush_cmd);
  assign flush_push = flush_cmd && !accept && (lane != '0) && !fifo_full;
  assign fifo_push  = byte_push || flush_push;
  assign fifo_pop   = pop_cmd && !fifo_empty;
  assign count_sat  = (int'(fifo_count) > 255) ? 8'hFF : 8'(fifo_count);

  // Compose the outgoing word: filled lanes, the arriving byte, pad above
  always_comb begin
    push_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(lane))
        push_word[8*i +: 8] = asm_word[8*i +: 8];
      else if ((i == int'(lane)) && accept)
        push_word[8*i +: 8] = in_data;
      else
        push_word[8*i +: 8] = pad;
    end
  end

  packer_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_cmd),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_word),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Lane counter and assembly register track the partially built word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      asm_word <= '0;
    end else if (clear_cmd) begin
      lane <= '0;
    end else if (fifo_push) begin
      lane <= '0;
    end else if (accept) begin
      asm_word[{lane, 3'b000} +: 8] <= in_data;
      lane                          <= lane + 1'b1;
    end
  end

  // Pad byte and sticky underflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad       <= 8'h00;
      underflow <= 1'b0;
    end else begin
      if (pad_cmd)                  pad       <= cmd_arg[7:0];
      if (clear_cmd)                underflow <= 1'b0;
      else if (pop_cmd && fifo_empty) underflow <= 1'b1;
    end
  end

`ifdef CONV1D_PACKER_STATS_EN
  logic [31:0] words_pushed;
  logic [31:0] stall_cycles;

  // Wrapping activity counters, zeroed by CLEAR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_pushed <= '0;
      stall_cycles <= '0;
    end else if (clear_cmd) begin
      words_pushed <= '0;
      stall_cycles <= '0;
    end else begin
      if (fifo_push)             words_pushed <= words_pushed + 1'b1;
      if (in_valid && !in_ready) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign words_val  = words_pushed;
  assign stalls_val = stall_cycles;
`else
  assign words_val  = '0;
  assign stalls_val = '0;
`endif

  // Command result decode; unknown opcodes return zero
  always_comb begin
    result = '0;
    case (cmd)
      OP_POP:    result = fifo_empty ? '0 : fifo_head;
      OP_STATUS: result = make_status(underflow, lane, count_sat);
      OP_WORDS:  result = words_val;
      OP_STALLS: result = stalls_val;
      default:   result = '0;
    endcase
  end

  // Result register holds until the next command; valid pulses one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret       <= '0;
      ret_valid <= 1'b0;
    end else begin
      ret_valid <= cmd_valid;
      if (cmd_valid) ret <= WORD_W'(result);
    end
  end

endmodule

// File: tb/tb_conv1d_output_packer.sv
// Directed self-checking bench for conv1d_output_packer.
module tb_conv1d_output_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        cmd_valid;
  logic [6:0]  cmd;
  logic [31:0] cmd_arg;
  logic [31:0] ret;
  logic        ret_valid;

  int pass_count = 0;
  int check_count = 0;

  localparam logic [6:0] OP_POP = 7'd20, OP_STATUS = 7'd21, OP_CLEAR = 7'd22,
                         OP_SET_PAD = 7'd23, OP_FLUSH = 7'd24, OP_WORDS = 7'd25;

  conv1d_output_packer #(.FIFO_DEPTH(64), .WORD_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_arg   (cmd_arg),
    .ret       (ret),
    .ret_valid (ret_valid)
  );

  always #5 clk = ~clk;

  // Called at posedge+1; returns at posedge+1 after the byte is accepted
  task automatic send_byte(input logic [7:0] d, input logic last);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      check_count++;
      $display("[TB] FAIL send_byte_timeout data=%02h in_ready never rose", d);
    end
  endtask

  // Issue one command; returns at posedge+1 with the registered result
  task automatic do_cmd(input logic [6:0] op, input logic [31:0] arg,
                        output logic [31:0] r, output logic rv);
    cmd_valid = 1'b1;
    cmd       = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    r  = ret;
    rv = ret_valid;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    @(negedge clk);
    check_count++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready);
    else pass_count++;
    check_count++;
    if (ret !== 32'h0 || ret_valid !== 1'b0)
      $display("[TB] FAIL reset_ret got=%08h/%b want=00000000/0", ret, ret_valid);
    else pass_count++;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_pack();
    logic [31:0] r;
    logic rv;
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    do_cmd(OP_POP, 0, r, rv);
    check_count++;
    if (r !== 32'h04030201 || rv !== 1'b1)
      $display("[TB] FAIL basic_pop got=%08h/%b want=04030201/1", r, rv);
    else pass_count++;
    @(posedge clk);
    #1;
    check_count++;
    if (ret_valid !== 1'b0 || ret !== 32'h04030201)
      $display("[TB] FAIL basic_pulse_hold got=%08h/%b want=04030201/0", ret, ret_valid);
    else pass_count++;
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h0) $display("[TB] FAIL basic_status got=%08h want=00000000", r);
    else pass_count++;
  endtask

  task automatic test_pad_last();
    logic [31:0] r;
    logic rv;
    do_cmd(OP_SET_PAD, 32'h000000AA, r, rv);
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    do_cmd(OP_POP, 0, r, rv);
    check_count++;
    if (r !== 32'hAAAA2211) $display("[TB] FAIL pad_last_pop got=%08h want=AAAA2211", r);
    else pass_count++;
    do_cmd(OP_SET_PAD, 32'h00000000, r, rv);
  endtask

  task automatic test_full_fifo();
    logic [31:0] r;
    logic [31:0] exp;
    logic rv;
    for (int k = 0; k < 256; k++) send_byte(8'(k), 0);
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    check_count++;
    if (in_ready !== 1'b0) $display("[TB] FAIL full_ready_low got=%b want=0", in_ready);
    else pass_count++;
    @(posedge clk);
    #1;
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h00000040) $display("[TB] FAIL full_status got=%08h want=00000040", r);
    else pass_count++;
    cmd_valid = 1'b1;
    cmd       = OP_POP;
    @(negedge clk);
    check_count++;
    if (in_ready !== 1'b0) $display("[TB] FAIL full_pop_same_cycle got=%b want=0", in_ready);
    else pass_count++;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_count++;
    if (ret !== 32'h03020100) $display("[TB] FAIL full_first_word got=%08h want=03020100", ret);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (in_ready !== 1'b1) $display("[TB] FAIL full_ready_reopen got=%b want=1", in_ready);
    else pass_count++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int j = 1; j < 64; j++) begin
      exp = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      do_cmd(OP_POP, 0, r, rv);
      check_count++;
      if (r !== exp) $display("[TB] FAIL full_order_%0d got=%08h want=%08h", j, r, exp);
      else pass_count++;
    end
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h00000100) $display("[TB] FAIL full_tail_status got=%08h want=00000100", r);
    else pass_count++;
    do_cmd(OP_CLEAR, 0, r, rv);
  endtask

  task automatic test_underflow_clear();
    logic [31:0] r;
    logic rv;
    do_cmd(OP_POP, 0, r, rv);
    check_count++;
    if (r !== 32'h0 || rv !== 1'b1) $display("[TB] FAIL underflow_pop got=%08h/%b want=00000000/1", r, rv);
    else pass_count++;
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h80000000) $display("[TB] FAIL underflow_status got=%08h want=80000000", r);
    else pass_count++;
    do_cmd(OP_CLEAR, 0, r, rv);
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h0) $display("[TB] FAIL clear_status got=%08h want=00000000", r);
    else pass_count++;
  endtask

  task automatic test_flush();
    logic [31:0] r;
    logic rv;
    do_cmd(OP_FLUSH, 0, r, rv);
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h0) $display("[TB] FAIL flush_empty_noop got=%08h want=00000000", r);
    else pass_count++;
    send_byte(8'h7F, 0);
    send_byte(8'h80, 0);
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h00000200) $display("[TB] FAIL flush_lane2 got=%08h want=00000200", r);
    else pass_count++;
    do_cmd(OP_FLUSH, 0, r, rv);
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h00000001) $display("[TB] FAIL flush_status got=%08h want=00000001", r);
    else pass_count++;
    do_cmd(OP_POP, 0, r, rv);
    check_count++;
    if (r !== 32'h0000807F) $display("[TB] FAIL flush_pop got=%08h want=0000807F", r);
    else pass_count++;
  endtask

  task automatic test_clear_with_byte();
    logic [31:0] r;
    logic rv;
    do_cmd(OP_SET_PAD, 32'h00000055, r, rv);
    send_byte(8'h01, 0);
    in_valid  = 1'b1;
    in_data   = 8'h99;
    cmd_valid = 1'b1;
    cmd       = OP_CLEAR;
    @(negedge clk);
    check_count++;
    if (in_ready !== 1'b0) $display("[TB] FAIL clear_blocks_byte got=%b want=0", in_ready);
    else pass_count++;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h0) $display("[TB] FAIL clear_byte_status got=%08h want=00000000", r);
    else pass_count++;
    send_byte(8'h33, 1);
    do_cmd(OP_POP, 0, r, rv);
    check_count++;
    if (r !== 32'h55555533) $display("[TB] FAIL clear_keeps_pad got=%08h want=55555533", r);
    else pass_count++;
    do_cmd(7'd5, 32'hFFFFFFFF, r, rv);
    check_count++;
    if (r !== 32'h0 || rv !== 1'b1) $display("[TB] FAIL unknown_opcode got=%08h/%b want=00000000/1", r, rv);
    else pass_count++;
    do_cmd(OP_SET_PAD, 32'h00000000, r, rv);
  endtask

  task automatic test_async_reset_midrow();
    logic [31:0] r;
    logic [31:0] exp_words;
    logic rv;
    for (int k = 0; k < 23; k++) send_byte(8'(k + 8'h40), 0);
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h00000305) $display("[TB] FAIL midrow_status got=%08h want=00000305", r);
    else pass_count++;
    rst_n = 1'b0;
    #1;
    check_count++;
    if (in_ready !== 1'b0 || ret !== 32'h0) $display("[TB] FAIL midrow_in_reset got=%b/%08h want=0/00000000", in_ready, ret);
    else pass_count++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h0) $display("[TB] FAIL after_reset_status got=%08h want=00000000", r);
    else pass_count++;
    do_cmd(OP_POP, 0, r, rv);
    check_count++;
    if (r !== 32'h0) $display("[TB] FAIL after_reset_pop got=%08h want=00000000", r);
    else pass_count++;
    do_cmd(OP_STATUS, 0, r, rv);
    check_count++;
    if (r !== 32'h80000000) $display("[TB] FAIL after_reset_underflow got=%08h want=80000000", r);
    else pass_count++;
    for (int k = 0; k < 8; k++) send_byte(8'(k), 0);
`ifdef CONV1D_PACKER_STATS_EN
    exp_words = 32'd2;
`else
    exp_words = 32'd0;
`endif
    do_cmd(OP_WORDS, 0, r, rv);
    check_count++;
    if (r !== exp_words) $display("[TB] FAIL words_pushed got=%08h want=%08h", r, exp_words);
    else pass_count++;
    do_cmd(OP_CLEAR, 0, r, rv);
    do_cmd(OP_WORDS, 0, r, rv);
    check_count++;
    if (r !== 32'h0) $display("[TB] FAIL words_after_clear got=%08h want=00000000", r);
    else pass_count++;
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 7'd0;
    cmd_arg   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_pack();
    test_pad_last();
    test_full_fifo();
    test_underflow_clear();
    test_flush();
    test_clear_with_byte();
    test_async_reset_midrow();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
